// File: rtl/bus_msg_assembler.sv
// Receive-side beat packer: collects owidth-bit beats LSB-first into one width-bit message
// and holds it on a single-entry output until the consumer accepts it.
module bus_msg_assembler #(
  parameter int unsigned width  = 144,
  parameter int unsigned owidth = 32,
  parameter int unsigned CW     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_enq__ENA,
  input  logic [owidth-1:0] in_enq_v,
  input  logic              in_enq_last,
  output logic              in_enq__RDY,
  output logic              out_enq__ENA,
  output logic [width-1:0]  out_enq_v,
  output logic [CW-1:0]     out_enq_beats,
  output logic              out_enq_err,
  input  logic              out_enq__RDY,
  input  logic              clear__ENA,
  output logic              clear__RDY
);

  localparam int unsigned NBEAT = (width + owidth - 1) / owidth;
  localparam int unsigned PADW  = NBEAT * owidth;

  typedef enum logic {COLLECT, DISCARD} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_idx;
  logic [width-1:0]    r_data;
  logic [CW-1:0]       r_beats;
  logic                r_err;
  logic                r_full;

  logic [PADW-1:0]     w_beat_pad;
  logic [PADW-1:0]     w_beat_sh;
  logic [width-1:0]    w_ins;

  // Beat placed at its slot; the padded shift drops bits past width.
  assign w_beat_pad = PADW'(in_enq_v);
  assign w_beat_sh  = w_beat_pad << (32'(r_idx) * owidth);
  assign w_ins      = width'(w_beat_sh);

  assign in_enq__RDY   = !r_full;
  assign out_enq__ENA  = r_full;
  assign out_enq_v     = r_data;
  assign out_enq_beats = r_beats;
  assign out_enq_err   = r_err;
  assign clear__RDY    = 1'b1;

  // Assembly register is zero at message start, so OR-ing each beat in is sufficient.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= COLLECT;
      r_idx   <= '0;
      r_data  <= '0;
      r_beats <= '0;
      r_err   <= 1'b0;
      r_full  <= 1'b0;
    end else if (clear__ENA) begin
      r_state <= COLLECT;
      r_idx   <= '0;
      r_data  <= '0;
      r_beats <= '0;
      r_err   <= 1'b0;
      r_full  <= 1'b0;
    end else if (r_full) begin
      if (out_enq__RDY) begin
        r_full  <= 1'b0;
        r_data  <= '0;
        r_beats <= '0;
        r_err   <= 1'b0;
      end
    end else if (in_enq__ENA) begin
      case (r_state)
        COLLECT: begin
          r_data  <= r_data | w_ins;
          r_beats <= r_beats + CW'(1);
          if (in_enq_last) begin
            r_full <= 1'b1;
            r_err  <= 1'b0;
            r_idx  <= '0;
          end else if (r_idx == CW'(NBEAT - 1)) begin
            r_state <= DISCARD;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + CW'(1);
          end
        end
        DISCARD: begin
          if (in_enq_last) begin
            r_full  <= 1'b1;
            r_err   <= 1'b1;
            r_beats <= CW'(NBEAT);
            r_state <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_msg_assembler.sv
// Self-checking bench for bus_msg_assembler: directed vector table, multi-cycle corner
// sequences, and randomized messages against a behavioural packing model.
module tb_bus_msg_assembler;

  localparam int unsigned W  = 144;
  localparam int unsigned OW = 32;
  localparam int unsigned NB = 5;
  localparam int unsigned CWB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic [OW-1:0] dat = '0;
  logic          lst = 1'b0;
  logic          in_rdy;
  logic          out_ena;
  logic [W-1:0]  out_v;
  logic [CWB-1:0] out_beats;
  logic          out_err;
  logic          ordy = 1'b0;
  logic          clr = 1'b0;
  logic          clr_rdy;

  int checks = 0;
  int errors = 0;

  bus_msg_assembler #(.width(W), .owidth(OW), .CW(CWB)) dut (
    .CLK          (clk),
    .RST          (rst),
    .in_enq__ENA  (ena),
    .in_enq_v     (dat),
    .in_enq_last  (lst),
    .in_enq__RDY  (in_rdy),
    .out_enq__ENA (out_ena),
    .out_enq_v    (out_v),
    .out_enq_beats(out_beats),
    .out_enq_err  (out_err),
    .out_enq__RDY (ordy),
    .clear__ENA   (clr),
    .clear__RDY   (clr_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned       n;
    logic [7:0][31:0]  d;
    logic [W-1:0]      v;
    int unsigned       nb;
    bit                err;
    int unsigned       hold;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference packing: beats LSB-first, truncated to W bits, at most NB beats kept.
  function automatic void model(input int unsigned n, input logic [7:0][31:0] d,
                                output logic [W-1:0] v, output int unsigned nb, output bit e);
    v  = '0;
    nb = (n > NB) ? NB : n;
    e  = (n > NB);
    for (int i = 0; i < int'(nb); i++) v = v | (W'(d[i]) << (32 * i));
  endfunction

  task automatic send_msg(input int unsigned n, input logic [7:0][31:0] d, input logic [W-1:0] ev,
                          input int unsigned eb, input bit ee, input int unsigned hold);
    for (int i = 0; i < int'(n); i++) begin
      int unsigned gap;
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      chk("in_rdy_during_msg", W'(in_rdy), W'(1));
      chk("out_ena_during_msg", W'(out_ena), W'(0));
      ena = 1'b1;
      dat = d[i];
      lst = (i == int'(n) - 1);
      tick();
      ena = 1'b0;
      lst = 1'b0;
    end
    chk("out_ena_after_last", W'(out_ena), W'(1));
    chk("out_v", out_v, ev);
    chk("out_beats", W'(out_beats), W'(eb));
    chk("out_err", W'(out_err), W'(ee));
    chk("in_rdy_full", W'(in_rdy), W'(0));
    for (int c = 0; c < int'(hold); c++) begin
      tick();
      chk("hold_ena", W'(out_ena), W'(1));
      chk("hold_v", out_v, ev);
      chk("hold_beats", W'(out_beats), W'(eb));
      chk("hold_in_rdy", W'(in_rdy), W'(0));
    end
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk("ena_after_xfer", W'(out_ena), W'(0));
    chk("in_rdy_after_xfer", W'(in_rdy), W'(1));
    chk("v_cleared", out_v, W'(0));
  endtask

  task automatic raw_beat(input logic [31:0] v, input bit last);
    ena = 1'b1;
    dat = v;
    lst = last;
    tick();
    ena = 1'b0;
    lst = 1'b0;
  endtask

  initial begin
    logic [7:0][31:0] d;
    logic [W-1:0]     mv;
    int unsigned      mn;
    bit               me;
    int unsigned      n;

    for (int k = 0; k < 6; k++) begin
      tbl[k].d = '0;
      tbl[k].hold = 0;
    end
    tbl[0].n = 5;
    tbl[0].d[0] = 32'h11111111; tbl[0].d[1] = 32'h22222222; tbl[0].d[2] = 32'h33333333;
    tbl[0].d[3] = 32'h44444444; tbl[0].d[4] = 32'h55555555;
    tbl[0].v = 144'h5555_44444444_33333333_22222222_11111111; tbl[0].nb = 5; tbl[0].err = 0;
    tbl[1].n = 2; tbl[1].d[0] = 32'hA; tbl[1].d[1] = 32'hB;
    tbl[1].v = 144'h0000000B_0000000A; tbl[1].nb = 2; tbl[1].err = 0;
    tbl[2].n = 1; tbl[2].d[0] = 32'hC;
    tbl[2].v = 144'hC; tbl[2].nb = 1; tbl[2].err = 0;
    tbl[3].n = 7;
    for (int k = 0; k < 7; k++) tbl[3].d[k] = 32'hF0000001 + 32'(k);
    tbl[3].v = 144'h0005_F0000004_F0000003_F0000002_F0000001; tbl[3].nb = 5; tbl[3].err = 1;
    tbl[4].n = 6;
    for (int k = 0; k < 6; k++) tbl[4].d[k] = 32'hFFFFFFFF;
    tbl[4].v = {144{1'b1}}; tbl[4].nb = 5; tbl[4].err = 1;
    tbl[5].n = 3; tbl[5].d[0] = 32'h1; tbl[5].d[1] = 32'h2; tbl[5].d[2] = 32'h3;
    tbl[5].v = 144'h00000003_00000002_00000001; tbl[5].nb = 3; tbl[5].err = 0; tbl[5].hold = 10;

    #1;
    chk("rst_in_rdy", W'(in_rdy), W'(1));
    chk("rst_out_ena", W'(out_ena), W'(0));
    chk("rst_v", out_v, W'(0));
    chk("rst_beats", W'(out_beats), W'(0));
    chk("rst_err", W'(out_err), W'(0));
    chk("clear_rdy", W'(clr_rdy), W'(1));
    ena = 1'b1; dat = 32'hDEADBEEF; lst = 1'b1;
    tick(); tick();
    chk("ena_ignored_in_rst", W'(out_ena), W'(0));
    ena = 1'b0; lst = 1'b0;
    rst = 1'b0;
    tick();

    for (int k = 0; k < 6; k++)
      send_msg(tbl[k].n, tbl[k].d, tbl[k].v, tbl[k].nb, tbl[k].err, tbl[k].hold);

    // Asynchronous reset in the middle of collection
    raw_beat(32'h12345678, 1'b0);
    raw_beat(32'h9ABCDEF0, 1'b0);
    chk("partial_nonzero", W'(out_v != '0), W'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_v", out_v, W'(0));
    chk("async_rst_beats", W'(out_beats), W'(0));
    chk("async_rst_in_rdy", W'(in_rdy), W'(1));
    tick();
    rst = 1'b0;
    d = '0; d[0] = 32'h5A;
    send_msg(1, d, W'(32'h5A), 1, 0, 0);

    // Clear after 3 beats with a last beat presented in the same cycle
    raw_beat(32'h1, 1'b0);
    raw_beat(32'h2, 1'b0);
    raw_beat(32'h3, 1'b0);
    clr = 1'b1;
    raw_beat(32'hDEAD, 1'b1);
    clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("clear_no_out", W'(out_ena), W'(0));
      tick();
    end
    d = '0; d[0] = 32'h77;
    send_msg(1, d, W'(32'h77), 1, 0, 0);

    // Clear coinciding with an output transfer
    raw_beat(32'h42, 1'b1);
    chk("pre_clear_full", W'(out_ena), W'(1));
    ordy = 1'b1; clr = 1'b1;
    tick();
    ordy = 1'b0; clr = 1'b0;
    chk("clear_xfer_ena", W'(out_ena), W'(0));
    chk("clear_xfer_in_rdy", W'(in_rdy), W'(1));
    chk("clear_xfer_v", out_v, W'(0));

    // Randomized messages against the behavioural model
    for (int m = 0; m < 40; m++) begin
      n = $urandom_range(1, 8);
      d = '0;
      for (int k = 0; k < 8; k++) d[k] = $urandom;
      model(n, d, mv, mn, me);
      send_msg(n, d, mv, mn, me, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
